// File: rtl/dl_write_buffer_if.sv
// Download-side strobe bus and SDRAM write-port handshake for dl_write_buffer.
// The slave modport is the buffer itself; master is the surrounding receiver/RAM side.
interface dl_write_buffer_if;
  logic        downloading;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [15:0] dl_data;
  logic        ram_req;
  logic [24:0] ram_addr;
  logic [15:0] ram_data;
  logic        ram_ack;

  modport slave (
    input  downloading, dl_wr, dl_addr, dl_data, ram_ack,
    output ram_req, ram_addr, ram_data
  );

  modport master (
    output downloading, dl_wr, dl_addr, dl_data, ram_ack,
    input  ram_req, ram_addr, ram_data
  );
endinterface

// File: rtl/dl_write_buffer.sv
// Queues SPI download word strobes in a small FIFO and drains them into a shared
// SDRAM write port over a req/ack handshake, reporting busy/done/count/overflow.
module dl_write_buffer #(
  parameter int DEPTH_LOG2 = 3,
  parameter bit SWAP_BYTES = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  dl_write_buffer_if.slave  bus,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [24:0]       words_written
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t                state, state_next;
  logic [DEPTH_LOG2:0]   wr_ptr, rd_ptr;
  logic [24:0]           addr_mem [DEPTH];
  logic [15:0]           data_mem [DEPTH];
  logic                  empty, full, pop, push, drop, load, start;
  logic                  downloading_p1, busy_p1;

  function automatic logic [15:0] order_bytes(input logic [15:0] d);
    return SWAP_BYTES ? {d[7:0], d[15:8]} : d;
  endfunction

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign pop   = (state == REQ) && bus.ram_ack;
  // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
  assign push  = bus.dl_wr && (!full || pop);
  assign drop  = bus.dl_wr && full && !pop;
  assign start = bus.downloading && !downloading_p1;
  assign busy  = reset_n && (bus.downloading || !empty || bus.ram_req);

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        state_next = REQ;
        load       = 1'b1;
      end
      REQ:  if (bus.ram_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr[DEPTH_LOG2-1:0]] <= bus.dl_addr;
      data_mem[wr_ptr[DEPTH_LOG2-1:0]] <= bus.dl_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      bus.ram_req    <= 1'b0;
      bus.ram_addr   <= '0;
      bus.ram_data   <= '0;
      downloading_p1 <= 1'b0;
      busy_p1        <= 1'b0;
      done           <= 1'b0;
      overflow       <= 1'b0;
      words_written  <= '0;
    end else begin
      state          <= state_next;
      downloading_p1 <= bus.downloading;
      busy_p1        <= busy;
      done           <= busy_p1 & ~busy;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (load) begin
        bus.ram_req  <= 1'b1;
        bus.ram_addr <= addr_mem[rd_ptr[DEPTH_LOG2-1:0]];
        bus.ram_data <= order_bytes(data_mem[rd_ptr[DEPTH_LOG2-1:0]]);
      end else if (pop) begin
        bus.ram_req  <= 1'b0;
      end
      // Download start clears status; an event in the same cycle still counts.
      if (start)     overflow <= drop;
      else if (drop) overflow <= 1'b1;
      if (start)     words_written <= {24'd0, pop};
      else if (pop)  words_written <= words_written + 25'd1;
    end
  end
endmodule

// File: tb/tb_dl_write_buffer.sv
// Directed bench for dl_write_buffer: reset, latency, overflow, full+pop,
// byte swap and pointer wrap, with expected words held in a queue.
module tb_dl_write_buffer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        busy0, done0, ovf0, busy1, done1, ovf1;
  logic [24:0] ww0, ww1;
  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  logic [40:0] exp_q[$];

  dl_write_buffer_if bus0 ();
  dl_write_buffer_if bus1 ();

  dl_write_buffer #(.DEPTH_LOG2(3), .SWAP_BYTES(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0),
    .busy(busy0), .done(done0), .overflow(ovf0), .words_written(ww0)
  );

  dl_write_buffer #(.DEPTH_LOG2(3), .SWAP_BYTES(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1),
    .busy(busy1), .done(done1), .overflow(ovf1), .words_written(ww1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done0) done_cnt <= done_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [24:0] a, input logic [15:0] d, input bit keep);
    bus0.dl_wr   = 1'b1;
    bus0.dl_addr = a;
    bus0.dl_data = d;
    if (keep) exp_q.push_back({a, d});
    tick();
    bus0.dl_wr = 1'b0;
  endtask

  // Wait for a request, check it against the queue head, hold, then ack once.
  task automatic serve(input int delay);
    logic [40:0] e;
    int guard;
    e = exp_q.pop_front();
    guard = 0;
    while (!bus0.ram_req && guard < 40) begin
      tick();
      guard++;
    end
    check("req_seen", bus0.ram_req, 1);
    check("wr_addr", bus0.ram_addr, e[40:16]);
    check("wr_data", bus0.ram_data, e[15:0]);
    for (int i = 0; i < delay; i++) begin
      tick();
      check("hold", {bus0.ram_req, bus0.ram_addr, bus0.ram_data}, {1'b1, e});
    end
    bus0.ram_ack = 1'b1;
    tick();
    bus0.ram_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int cnt;
    int dc;
    logic [40:0] e;
    reset_n = 1'b0;
    bus0.downloading = 0; bus0.dl_wr = 0; bus0.dl_addr = '0; bus0.dl_data = '0; bus0.ram_ack = 0;
    bus1.downloading = 0; bus1.dl_wr = 0; bus1.dl_addr = '0; bus1.dl_data = '0; bus1.ram_ack = 0;
    tick(); tick();
    check("rst_req", bus0.ram_req, 0);
    check("rst_addr_data", {bus0.ram_addr, bus0.ram_data}, 0);
    check("rst_status", {busy0, done0, ovf0}, 0);
    check("rst_ww", ww0, 0);
    reset_n = 1'b1;
    tick();

    // Reset in the middle of a request with words queued
    bus0.downloading = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) push_word(25'h000100 + 25'(i), 16'h1100 + 16'(i), 1'b0);
    check("midrst_pre_req", bus0.ram_req, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_req", bus0.ram_req, 0);
    check("midrst_busy", busy0, 0);
    check("midrst_ww", ww0, 0);
    bus0.downloading = 1'b0;
    tick();
    reset_n = 1'b1;
    cnt = 0;
    repeat (8) begin
      tick();
      if (bus0.ram_req) cnt++;
    end
    check("midrst_no_write", cnt, 0);
    check("midrst_idle_busy", busy0, 0);

    // Single word: two-cycle latency, stable hold, one done pulse
    bus0.downloading = 1'b1;
    tick();
    bus0.dl_wr = 1'b1; bus0.dl_addr = 25'h0; bus0.dl_data = 16'h1234;
    tick();
    bus0.dl_wr = 1'b0;
    check("single_lat1", bus0.ram_req, 0);
    tick();
    check("single_req", {bus0.ram_req, bus0.ram_addr, bus0.ram_data}, {1'b1, 25'h0, 16'h1234});
    repeat (3) begin
      tick();
      check("single_hold", {bus0.ram_req, bus0.ram_addr, bus0.ram_data}, {1'b1, 25'h0, 16'h1234});
    end
    bus0.ram_ack = 1'b1;
    tick();
    bus0.ram_ack = 1'b0;
    check("single_req_low", bus0.ram_req, 0);
    check("single_ww", ww0, 1);
    dc = done_cnt;
    bus0.downloading = 1'b0;
    tick();
    check("single_done", {busy0, done0}, 2'b01);
    repeat (5) tick();
    check("single_done_once", done_cnt - dc, 1);

    // Burst of 8 with RAM stalled, 9th dropped, then drain
    bus0.downloading = 1'b1;
    tick();
    check("start_clr_ww", ww0, 0);
    for (int i = 0; i < 8; i++) push_word(25'h7FFFFF + 25'(i), 16'hB000 + 16'(i), 1'b1);
    check("burst_no_ovf", ovf0, 0);
    push_word(25'h800007, 16'hDEAD, 1'b0);
    check("burst_ovf", ovf0, 1);
    for (int i = 0; i < 8; i++) serve(1);
    cnt = 0;
    repeat (6) begin
      tick();
      if (bus0.ram_req) cnt++;
    end
    check("burst_no_9th", cnt, 0);
    check("burst_ww", ww0, 8);
    check("burst_ovf_sticky", ovf0, 1);

    // Full FIFO with a coincident pop accepts the strobe
    bus0.downloading = 1'b0;
    tick();
    bus0.downloading = 1'b1;
    tick();
    check("start_clr_ovf", {ovf0, ww0}, 0);
    for (int i = 0; i < 8; i++) push_word(25'h000100 + 25'(i), 16'h4000 + 16'(i), 1'b1);
    e = exp_q.pop_front();
    check("fullpop_head", {bus0.ram_req, bus0.ram_addr, bus0.ram_data}, {1'b1, e});
    bus0.ram_ack = 1'b1;
    push_word(25'h0001AA, 16'h7777, 1'b1);
    bus0.ram_ack = 1'b0;
    check("fullpop_no_ovf", ovf0, 0);
    push_word(25'h0001BB, 16'h8888, 1'b0);
    check("fullpop_still_full", ovf0, 1);
    for (int i = 0; i < 8; i++) serve(0);
    check("fullpop_ww", ww0, 9);
    bus0.downloading = 1'b0;
    repeat (4) tick();

    // Pointer wrap: 40 words in batches, random ack delays
    bus0.downloading = 1'b1;
    tick();
    dc = done_cnt;
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 5; i++) begin
        int n;
        n = b * 5 + i;
        push_word(25'h0A0000 + 25'(n * 3), 16'(n * 16'h0101) ^ 16'h5A00, 1'b1);
      end
      if (b == 7) bus0.downloading = 1'b0;
      for (int i = 0; i < 5; i++) serve(int'($urandom_range(0, 5)));
    end
    repeat (3) tick();
    check("wrap_ww", ww0, 40);
    check("wrap_ovf", ovf0, 0);
    check("wrap_queue_empty", exp_q.size(), 0);
    check("wrap_done_once", done_cnt - dc, 1);
    check("wrap_busy", busy0, 0);

    // Byte-swapping instance and status clear on a second start
    bus1.downloading = 1'b1;
    tick();
    bus1.dl_wr = 1'b1; bus1.dl_addr = 25'h123456; bus1.dl_data = 16'hA55A;
    tick();
    bus1.dl_wr = 1'b0;
    tick();
    check("swap_req", {bus1.ram_req, bus1.ram_addr, bus1.ram_data}, {1'b1, 25'h123456, 16'h5AA5});
    bus1.ram_ack = 1'b1;
    tick();
    bus1.ram_ack = 1'b0;
    check("swap_ww", ww1, 1);
    bus1.downloading = 1'b0;
    tick();
    bus1.downloading = 1'b1;
    tick();
    check("swap_restart_clr", {ovf1, ww1}, 0);
    bus1.downloading = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
